// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding and sizing constants for the data-memory responder
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W  = 3;
    localparam int WORD_W = 32;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with write enable and registered read port
module dmem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Array contents are deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage load/store responder with configurable wait states and stall
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        addr_errM
);
    localparam state_t AFTER_ACCEPT = (LATENCY > 0) ? WAIT : DONE;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  lat_idx;
    logic [WORD_W-1:0]  lat_data;
    logic               lat_we;
    logic               aligned;
    logic               accept;
    logic               enter_done;
    logic [ADDR_W-1:0]  ram_addr;
    logic [WORD_W-1:0]  ram_wdata;
    logic               is_store;
    logic               unused_addr;

    assign aligned     = (aluoutM[1:0] == 2'b00);
    assign unused_addr = ^aluoutM[31:ADDR_W+2];

    always_comb begin
        state_nx  = state;
        stallM    = 1'b0;
        addr_errM = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (memenM) begin
                    if (aligned) begin
                        accept   = 1'b1;
                        stallM   = 1'b1;
                        state_nx = AFTER_ACCEPT;
                    end else begin
                        addr_errM = 1'b1;
                    end
                end
            end
            WAIT: begin
                stallM = 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // With zero wait states the RAM is hit on the accept edge, so bypass the latches.
    assign enter_done = (state_nx == DONE) && (state != DONE);
    assign ram_addr   = accept ? aluoutM[ADDR_W+1:2] : lat_idx;
    assign ram_wdata  = accept ? writedataM : lat_data;
    assign is_store   = accept ? memwriteM : lat_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_idx  <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_idx  <= aluoutM[ADDR_W+1:2];
                lat_data <= writedataM;
                lat_we   <= memwriteM;
                cnt      <= CNT_W'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (enter_done & is_store),
        .re    (enter_done & ~is_store),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (readdataM)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for two responders (LATENCY 2 and 0)
module tb_dmem_responder;
    localparam int AW    = 10;
    localparam int WORDS = 2**AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        memen0, memen1, memwrite;
    logic [31:0] aluout, wdata;
    logic [31:0] rd0, rd1;
    logic        stall0, stall1, err0, err1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .memenM(memen0), .memwriteM(memwrite),
        .aluoutM(aluout), .writedataM(wdata), .readdataM(rd0),
        .stallM(stall0), .addr_errM(err0)
    );

    dmem_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .memenM(memen1), .memwriteM(memwrite),
        .aluoutM(aluout), .writedataM(wdata), .readdataM(rd1),
        .stallM(stall1), .addr_errM(err1)
    );

    typedef struct {
        logic [31:0] v;
        bit          chk;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mm[2][WORDS];
    bit          known[2][WORDS];
    logic [31:0] last_rd[2];
    bit          last_known[2];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic f_stall(int d);
        return (d != 0) ? stall1 : stall0;
    endfunction

    function automatic logic f_err(int d);
        return (d != 0) ? err1 : err0;
    endfunction

    function automatic logic [31:0] f_rd(int d);
        return (d != 0) ? rd1 : rd0;
    endfunction

    task automatic drive_en(int d, logic en);
        if (d != 0) memen1 = en;
        else        memen0 = en;
    endtask

    // Monitor: a DONE cycle is the first non-stalled cycle after a stalled run.
    int   scnt[2];
    bit   pst[2];
    logic s_m;
    exp_t e_m;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            s_m = f_stall(d);
            if (rst) begin
                scnt[d] = 0;
                pst[d]  = 0;
            end else if (s_m) begin
                scnt[d]++;
                pst[d] = 1;
            end else begin
                if (pst[d]) begin
                    check("stall_cycles", scnt[d], (d != 0) ? 32'd1 : 32'd3);
                    if ((d != 0 ? q1.size() : q0.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: dut %0d completed with no access pending", d);
                    end else begin
                        e_m = (d != 0) ? q1.pop_front() : q0.pop_front();
                        if (e_m.chk) check("readdata", f_rd(d), e_m.v);
                    end
                end
                scnt[d] = 0;
                pst[d]  = 0;
            end
        end
    end

    // Called at posedge+1 with the selected DUT idle; returns at posedge+1 back in IDLE.
    task automatic access(int d, bit we, logic [31:0] addr, logic [31:0] data, bit perturb);
        int   idx;
        int   k;
        exp_t e;
        idx = int'((addr >> 2) % WORDS);
        memwrite = we;
        aluout   = addr;
        wdata    = data;
        drive_en(d, 1'b1);
        #1;
        if (addr[1:0] != 2'b00) begin
            check("addr_err", f_err(d), 1);
            check("stall_on_err", f_stall(d), 0);
            @(posedge clk); #1;
            drive_en(d, 1'b0);
            if (last_known[d]) check("rd_unchanged", f_rd(d), last_rd[d]);
            return;
        end
        check("addr_err_clear", f_err(d), 0);
        check("stall_accept", f_stall(d), 1);
        if (we) begin
            e.v   = last_rd[d];
            e.chk = last_known[d];
            mm[d][idx]    = data;
            known[d][idx] = 1;
        end else begin
            e.v   = mm[d][idx];
            e.chk = known[d][idx];
            last_rd[d]    = e.v;
            last_known[d] = e.chk;
        end
        if (d != 0) q1.push_back(e);
        else        q0.push_back(e);
        @(posedge clk); #1;
        drive_en(d, 1'b0);
        if (perturb) begin
            aluout = 32'h0000_0080;
            wdata  = 32'h1234_5678;
        end
        k = 0;
        while (f_stall(d) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: dut %0d stalled for %0d cycles", d, k);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; memen0 = 0; memen1 = 0; memwrite = 0; aluout = 0; wdata = 0;
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = 0; last_known[d] = 1;
            for (int i = 0; i < WORDS; i++) known[d][i] = 0;
        end
        #1;
        check("reset_stall0", stall0, 0);
        check("reset_err0", err0, 0);
        check("reset_rd0", rd0, 0);
        check("reset_rd1", rd1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // LATENCY=2 directed sequence
        access(0, 1, 32'h80, 32'h0BAD_F00D, 0);
        access(0, 1, 32'h40, 32'hDEAD_BEEF, 0);
        access(0, 0, 32'h40, 0, 0);
        access(0, 0, 32'h42, 0, 0);
        access(0, 0, 32'h40, 0, 0);
        access(0, 1, 32'h48, 32'hCAFE_0001, 1);
        access(0, 0, 32'h48, 0, 1);
        access(0, 0, 32'h80, 0, 0);
        access(0, 1, 32'h44, 32'hA5A5_A5A5, 0);

        // store abandoned by reset while waiting
        memwrite = 1; aluout = 32'h44; wdata = 32'hFFFF_0000; memen0 = 1;
        @(posedge clk); #1;
        memen0 = 0;
        check("abort_in_wait", stall0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_stall", stall0, 0);
        check("abort_rd", rd0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = 0; last_known[d] = 1;
        end
        @(posedge clk); #1;
        access(0, 0, 32'h44, 0, 0);
        access(0, 1, 32'h1000, 32'h55, 0);
        access(0, 0, 32'h0000, 0, 0);

        // LATENCY=0 directed sequence
        access(1, 1, 32'h10, 32'h1111_2222, 0);
        access(1, 0, 32'h10, 0, 0);
        access(1, 0, 32'h13, 0, 0);
        access(1, 0, 32'h2010, 0, 1);

        // randomized mix on both responders
        for (int n = 0; n < 60; n++) begin
            int          d;
            logic [31:0] a;
            d = $urandom_range(0, 1);
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            access(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
